// File: rtl/instr_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction prefetch queue between the IF stage and a single-cycle-latency
// instruction BRAM. It holds up to DEPTH consecutive instruction words that
// start at head_pc. A request that falls inside the queue is served in the same
// cycle. A request outside the queue flushes it and refetches from the new
// address. Sequential reads keep the queue topped up.
//
// Optional feature (compile-time macro):
//   PREFETCH_BYPASS_EN - when defined, the BRAM response for the requested
//                        address is forwarded to instr in its arrival cycle.
//                        This cuts the miss penalty from 2 cycles to 1.
//
// Parameters:
//   DEPTH      - queue entries (power of two, 2..16)
//   IM_ADDR_W  - word-address width of the instruction BRAM
//
// Ports:
//   clock      - sole clock, all state updates on posedge
//   reset      - synchronous, active-high
//   addr       - word address requested by the IF stage
//   instr      - instruction at addr (NOP while stalled)
//   stall      - 1 = instr not available this cycle
//   bram_en    - BRAM read enable
//   bram_addr  - BRAM word address (0 when no read is issued)
//   bram_dout  - BRAM read data, valid one cycle after bram_en
// ----------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int DEPTH     = 4,
    parameter int IM_ADDR_W = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    output logic [31:0]          instr,
    output logic                 stall,
    output logic                 bram_en,
    output logic [IM_ADDR_W-1:0] bram_addr,
    input  logic [31:0]          bram_dout
);

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = IDX_W + 1;
    localparam logic [31:0] NOP   = 32'h2100_0000;

    // Circular storage. Entry k of the logical queue lives at head_idx + k.
    logic [31:0]      queue_mem [DEPTH];
    logic [IDX_W-1:0] head_idx_reg, head_idx_next;
    logic [31:0]      head_pc_reg, head_pc_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             in_flight_reg, in_flight_next;

    logic [31:0]      k;
    logic [31:0]      count_ext;
    logic             hit;
    logic             pending;
    logic             redirect;
    logic             room;
    logic             append;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] tail_idx;

    always_comb begin
        k         = addr - head_pc_reg;
        count_ext = {{(32 - CNT_W){1'b0}}, count_reg};
        hit       = (k < count_ext);
        // The requested word is the one arriving from the BRAM right now.
        // This is not a redirect: the refill already under way will deliver it.
        pending   = in_flight_reg && (k == count_ext);
        redirect  = !hit && !pending;
        rd_idx    = head_idx_reg + k[IDX_W-1:0];
        // Tail slot is computed from the pre-pop head and count. A pop in the
        // same cycle does not move where the arriving word belongs.
        tail_idx  = head_idx_reg + count_reg[IDX_W-1:0];
        // Reserve a slot for the read already in flight so the queue never
        // overflows.
        room      = (count_reg + {{(CNT_W - 1){1'b0}}, in_flight_reg}) < CNT_W'(DEPTH);
        // A response arriving during a redirect belongs to the old stream.
        append    = in_flight_reg && !redirect;
    end

    // Output side
    always_comb begin
        instr     = NOP;
        stall     = 1'b1;
        bram_en   = 1'b0;
        bram_addr = '0;
        if (!reset) begin
            if (hit) begin
                instr = queue_mem[rd_idx];
                stall = 1'b0;
            end
`ifdef PREFETCH_BYPASS_EN
            else if (pending) begin
                instr = bram_dout;
                stall = 1'b0;
            end
`endif
            if (redirect) begin
                bram_en   = 1'b1;
                bram_addr = addr[IM_ADDR_W-1:0];
            end else if (room) begin
                bram_en   = 1'b1;
                bram_addr = fetch_pc_reg[IM_ADDR_W-1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        head_idx_next  = head_idx_reg;
        head_pc_next   = head_pc_reg;
        fetch_pc_next  = fetch_pc_reg;
        count_next     = count_reg;
        in_flight_next = in_flight_reg;
        if (redirect) begin
            head_pc_next   = addr;
            fetch_pc_next  = addr + 32'd1;
            count_next     = '0;
            in_flight_next = 1'b1;
        end else begin
            // Drop entries in front of addr. A simultaneous append adds one.
            head_pc_next   = addr;
            head_idx_next  = rd_idx;
            count_next     = count_reg - k[CNT_W-1:0] + {{(CNT_W - 1){1'b0}}, append};
            in_flight_next = room;
            if (room) begin
                fetch_pc_next = fetch_pc_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_idx_reg  <= '0;
            head_pc_reg   <= '0;
            fetch_pc_reg  <= '0;
            count_reg     <= '0;
            in_flight_reg <= 1'b0;
        end else begin
            head_idx_reg  <= head_idx_next;
            head_pc_reg   <= head_pc_next;
            fetch_pc_reg  <= fetch_pc_next;
            count_reg     <= count_next;
            in_flight_reg <= in_flight_next;
        end
    end

    // Data storage has no reset. Validity is tracked by count_reg alone.
    always_ff @(posedge clock) begin
        if (!reset && append) begin
            queue_mem[tail_idx] <= bram_dout;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_buffer
//
// Bench for instr_prefetch_buffer with DEPTH=4 and IM_ADDR_W=14.
//
// The bench has two phases:
//   1. A table of directed vectors: reset, priming, a sequential stream,
//      a data_stall hold, a forward jump, a backward jump and reset during
//      a refill.
//   2. Randomized addresses checked against an address-list reference model.
//
// The BRAM model returns random data when no read was issued the cycle before.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam int          AW    = 14;
    localparam logic [31:0] NOP   = 32'h2100_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam bit          BYP   = 1'b1;
`else
    localparam bit          BYP   = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [31:0]   addr;
    logic [31:0]   instr;
    logic          stall;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_dout;

    logic [31:0]   mem [0:(1 << AW) - 1];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    instr_prefetch_buffer #(
        .DEPTH     (DEPTH),
        .IM_ADDR_W (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .instr     (instr),
        .stall     (stall),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-cycle-latency BRAM. Returns garbage when no read was issued.
    always @(posedge clock) begin
        if (bram_en) bram_dout <= mem[bram_addr];
        else         bram_dout <= $urandom;
    end

    typedef struct {
        bit          rst;
        logic [31:0] a;
        bit          es;
        logic [31:0] ei;
        bit          een;
        logic [13:0] eba;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [31:0] a, input bit es,
                       input logic [31:0] ei, input bit een, input logic [13:0] eba);
        vec_t v;
        v.rst = rst; v.a = a; v.es = es; v.ei = ei; v.een = een; v.eba = eba;
        vecs.push_back(v);
    endtask

    // Cycle in which the requested word arrives from the BRAM.
    task automatic add_pend(input logic [31:0] a, input logic [31:0] data,
                            input logic [13:0] eba);
        add(1'b0, a, !BYP, BYP ? data : NOP, 1'b1, eba);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    endtask

    task automatic step(input bit rst, input logic [31:0] a, input bit es,
                        input logic [31:0] ei, input bit een, input logic [13:0] eba);
        @(negedge clock);
        reset = rst;
        addr  = a;
        #1;
        $display("cyc %0d rst=%0d addr=%h stall=%0d instr=%h bram_en=%0d bram_addr=%h",
                 cyc, rst, a, stall, instr, bram_en, bram_addr);
        chk("stall",     {31'd0, stall},          {31'd0, es});
        chk("instr",     instr,                   ei);
        chk("bram_en",   {31'd0, bram_en},        {31'd0, een});
        chk("bram_addr", {18'd0, bram_addr},      {18'd0, eba});
        cyc++;
    endtask

    // Reference model: the list of buffered word addresses plus the address of
    // the read in flight. Instruction data comes straight from the BRAM content.
    logic [31:0] mq[$];
    bit          m_if;
    logic [31:0] m_if_addr;

    initial begin
        reset = 1'b1;
        addr  = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) begin
            mem[i]        = 32'h100 + i;
            mem[32'h40+i] = 32'hABC + i;
        end

        // rst, addr, stall, instr, bram_en, bram_addr
        add(1, 0, 1, NOP, 0, 0);
        add(1, 0, 1, NOP, 0, 0);
        add(0, 0, 1, NOP, 1, 0);                   // miss after reset: read 0
        add_pend(0, 32'h100, 1);
        add(0, 0, 0, 32'h100, 1, 2);
        add(0, 1, 0, 32'h101, 1, 3);               // sequential stream
        add(0, 2, 0, 32'h102, 1, 4);
        add(0, 3, 0, 32'h103, 1, 5);
        add(0, 3, 0, 32'h103, 1, 6);               // data_stall hold at 3
        add(0, 3, 0, 32'h103, 0, 0);               // queue full: no read
        add(0, 3, 0, 32'h103, 0, 0);
        add(0, 3, 0, 32'h103, 0, 0);
        add(0, 4, 0, 32'h104, 0, 0);
        add(0, 5, 0, 32'h105, 1, 7);
        add(0, 32'h40, 1, NOP, 1, 14'h40);         // jump: stale word 7 dropped
        add_pend(32'h40, 32'hABC, 14'h41);
        add(0, 32'h40, 0, 32'hABC, 1, 14'h42);
        add(0, 32'h41, 0, 32'hABD, 1, 14'h43);
        add(0, 32'h42, 0, 32'hABE, 1, 14'h44);
        add(0, 32'h43, 0, 32'hABF, 1, 14'h45);
        add(0, 32'h44, 0, 32'hAC0, 1, 14'h46);
        add(0, 32'h45, 0, 32'hAC1, 1, 14'h47);
        add(0, 32'h42, 1, NOP, 1, 14'h42);         // backward jump misses
        add_pend(32'h42, 32'hABE, 14'h43);
        add(0, 32'h42, 0, 32'hABE, 1, 14'h44);
        add(0, 6, 1, NOP, 1, 6);                   // jump, then reset mid-refill
        add(1, 6, 1, NOP, 0, 0);
        add(0, 6, 1, NOP, 1, 6);
        add_pend(6, 32'h106, 7);
        add(0, 6, 0, 32'h106, 1, 8);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].es, vecs[i].ei, vecs[i].een, vecs[i].eba);
        end

        // Randomized phase
        mq.delete();
        m_if      = 1'b0;
        m_if_addr = '0;
        begin
            logic [31:0] a;
            a = '0;
            for (int n = 0; n < 600; n++) begin
                bit          rst;
                bit          es;
                bit          een;
                logic [31:0] ei;
                logic [13:0] eba;
                int          r;
                int          pos;
                r   = $urandom_range(0, 99);
                rst = (n < 2) || (r < 3);
                if (!rst) begin
                    if      (r < 40) a = a;
                    else if (r < 85) a = a + 1;
                    else if (r < 93) a = a + $urandom_range(0, 12) - 6;
                    else if (r < 97) a = $urandom_range(0, 127);
                    else if (r < 99) a = 32'h4000 + $urandom_range(0, 15);
                    else             a = 32'hFFFF_FFFD;
                end
                if (rst) begin
                    es = 1; ei = NOP; een = 0; eba = 0;
                    mq.delete();
                    m_if = 1'b0;
                end else begin
                    pos = -1;
                    foreach (mq[i]) if (pos < 0 && mq[i] == a) pos = i;
                    if (pos < 0 && !(m_if && m_if_addr == a)) begin
                        // Miss: flush the list and refetch from a.
                        es = 1; ei = NOP; een = 1; eba = a[13:0];
                        mq.delete();
                        m_if      = 1'b1;
                        m_if_addr = a;
                    end else begin
                        logic [31:0] nxt;
                        bit          issue;
                        if (pos >= 0) begin
                            es = 0; ei = mem[a[13:0]];
                        end else begin
                            es = !BYP; ei = BYP ? mem[a[13:0]] : NOP;
                        end
                        nxt   = m_if ? m_if_addr + 1 : mq[mq.size() - 1] + 1;
                        issue = (mq.size() + int'(m_if)) < DEPTH;
                        een   = issue;
                        eba   = issue ? nxt[13:0] : 14'd0;
                        if (pos < 0) mq.delete();
                        else while (mq[0] != a) void'(mq.pop_front());
                        if (m_if) mq.push_back(m_if_addr);
                        m_if      = issue;
                        m_if_addr = nxt;
                    end
                end
                step(rst, a, es, ei, een, eba);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter IM_ADDR_W, default 14: word-address width of the instruction BRAM.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port addr, input, 32: word address requested by IF stage (slave side of InstructionMemory).
REQ-006 SHALL have port instr, output, 32: instruction at addr, valid when stall=0.
REQ-007 SHALL have port stall, output, 1: 1 = instr not available this cycle.
REQ-008 SHALL have port bram_en, output, 1: BRAM read enable.
REQ-009 SHALL have port bram_addr, output, IM_ADDR_W: BRAM word address (addr[IM_ADDR_W-1:0]).
REQ-010 SHALL have port bram_dout, input, 32: BRAM read data, valid exactly 1 cycle after the bram_en=1 cycle.

Function
REQ-011 SHALL hold a queue of up to DEPTH consecutive instructions starting at head_pc, with count entries, plus in_flight (0/1) BRAM reads outstanding.
REQ-012 SHALL compute k = addr - head_pc (32-bit unsigned); hit when k < count; addr below head_pc wraps to a large k and misses.
REQ-013 On hit SHALL drive instr = entry k, stall=0 combinationally, and at the clock edge drop entries 0..k-1 (head_pc <= addr, count -= k); entry k is retained.
REQ-014 On miss SHALL drive stall=1 and instr=32'h21000000 (NOP).
REQ-015 On miss (redirect) SHALL flush queue (count <= 0), set head_pc <= addr, issue bram_en=1 with bram_addr=addr in the same cycle, set fetch_pc <= addr+1, and discard any response arriving in the next cycle from an earlier read.
REQ-016 Otherwise SHALL issue a sequential read at fetch_pc (fetch_pc <= fetch_pc+1) iff count + in_flight < DEPTH, evaluated on pre-pop values; queue SHALL never overflow.
REQ-017 Valid responses SHALL be appended at the tail in issue order.
REQ-018 Unchanged addr across cycles (IF data_stall) SHALL keep hitting the same entry with no pop.
REQ-019 Simultaneous hit-with-pop and response append in one cycle SHALL both take effect: count_next = count - k + 1.
REQ-020 Miss penalty SHALL be 2 stall cycles (1 with bypass, see REQ-026); sequential stream at 1 instr/cycle SHALL have zero stalls once the queue is primed.
REQ-021 bram_addr/bram_en SHALL be 0 in cycles with no read issued.

Reset
REQ-022 While reset=1: count=0, in_flight=0, head_pc=0, fetch_pc=0, bram_en=0, stall=1, instr=NOP; pending responses discarded.
REQ-023 First cycle after reset SHALL issue a read at address 0 (treated as miss on addr=0 if addr=0).
REQ-024 Reset asserted mid-refill SHALL drop the in-flight response returning in the following cycle.

Configuration
REQ-025 Macro PREFETCH_BYPASS_EN SHALL select response bypass.
REQ-026 Defined: a valid response whose address equals addr SHALL be forwarded to instr with stall=0 in its arrival cycle (and still enqueued); miss penalty 1 cycle.
REQ-027 Undefined: responses are visible only after being written to the queue; miss penalty 2 cycles; no combinational path bram_dout -> instr.

Verification
REQ-028 Reset, addr held 0, BRAM[0..7]=0x100+i -> stall=1 for 2 cycles (1 with bypass), then instr=0x100, stall=0.
REQ-029 After priming, addr increments 0..7 every cycle -> instr=0x100..0x107, stall=0 every cycle, count never exceeds 4.
REQ-030 Addr held at 3 for 5 cycles (data_stall) -> instr=0x103 all 5 cycles, no pop, bram_en=0 once queue full.
REQ-031 At addr=4 jump to addr=0x40 (BRAM[0x40]=0xABC) -> stall=1, bram_addr=0x40 same cycle, stale response for 5/6 discarded, instr=0xABC after penalty.
REQ-032 Backward jump 0x45 -> 0x42 with 0x42 not in queue -> treated as miss, flush, refill from 0x42.
REQ-033 Reset asserted for 1 cycle during refill -> bram_en=0, stall=1 that cycle; next valid instr is BRAM[addr] fetched after reset.
